instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the MIPS core, directly upstream of the control decoder. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small FIFO and presents them to decode over valid/ready; `instr[31:26]` drives the control decoder's opcode input. Accepts PC redirects from branch/jump resolution.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset; word aligned.
- `DEPTH`, default `2`: FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  byte address of the request; low two bits always 0.
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decode accepts the head.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `instr_pc + 4`, modulo 2^32.
- `fetch_misalign`  out  1  sticky fault flag (see Configuration).

## Operation
- FSM states:
  - `FS_IDLE`: no request outstanding, `imem_req`=0.
  - `FS_REQ`: request outstanding.
  - `FS_DROP`: outstanding request whose data will be discarded.
  - `FS_FAULT`: halted.
- Reset:
  - State `FS_IDLE`, fetch PC = `RESET_PC`, FIFO empty, storage zeroed.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `pc_plus4`=4, `fetch_misalign`=0.
  - Reset mid-transaction drops the outstanding request with no further action.
- Issue rule: at most one outstanding request. `imem_req` is registered; it is 1 next cycle iff the next state is `FS_REQ` or `FS_DROP`.
- `FS_IDLE`→`FS_REQ` when the next-cycle FIFO count < `DEPTH`.
- In `FS_REQ`, `imem_req` and `imem_addr` are held until `imem_ack`. Requests are never withdrawn.
- On `imem_ack` in `FS_REQ`:
  - Push {PC, rdata}; fetch PC += 4 (wraps at 2^32).
  - Stay in `FS_REQ` with the new address if post-update count < `DEPTH`, else go to `FS_IDLE`.
- Pop when `instr_valid && instr_ready`. Push and pop may occur in the same cycle; the count is unchanged.
- `redirect` has priority over push and pop in the same cycle:
  - FIFO is cleared and fetch PC = `redirect_pc`.
  - If a request is outstanding and `imem_ack`=0 → `FS_DROP`.
  - If `imem_ack`=1 the same cycle, the data is discarded and the next state is `FS_REQ` at `redirect_pc`.
  - If no request is outstanding → `FS_REQ` next cycle.
- `FS_DROP`: hold the old address until `imem_ack`, discard the data, then `FS_REQ` at the redirected PC. A second redirect while in `FS_DROP` updates the target PC only.

## Timing
- Zero-wait memory (`ack` in the same cycle as `req`): first `imem_req` in cycle 1 after `rst` falls; `instr_valid` in cycle 2.
- Latency from `imem_ack` to `instr_valid`: 1 cycle.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and `instr_ready` held high.
- `instr_valid` drops the cycle after a redirect. The first redirected word is valid 2 cycles after the redirect with zero-wait memory and nothing outstanding.
- `instr`, `instr_pc` and `pc_plus4` are stable while `instr_valid && !instr_ready`.

## Configuration
- Macro: `IFETCH_ALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the FIFO and sets `fetch_misalign`=1.
  - The FSM enters `FS_FAULT` immediately if nothing is outstanding; otherwise it first drains the outstanding request through `FS_DROP`.
  - `FS_FAULT` issues no requests and holds `instr_valid`=0 until `rst`.
- Undefined: `redirect_pc[1:0]` is ignored (treated as 00); `fetch_misalign` is tied 0; `FS_FAULT` is unreachable.

## Structure
- Package `mips_pkg` holds:
  - `word_t` (32-bit logic).
  - `fetch_state_t` enum {`FS_IDLE`, `FS_REQ`, `FS_DROP`, `FS_FAULT`}.
  - `RESET_PC_DEFAULT` and the `WORD_BYTES`=4 constant.
- Sub-module `fetch_fifo`: parameterised `DEPTH` FIFO of {pc, instr}.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.

## Test plan
- Reset release with zero-wait memory, `instr_ready`=1:
  - `imem_addr` sequence 0,4,8,C.
  - `instr_valid` from cycle 2.
  - `instr_pc`/`instr` match memory every cycle.
- `instr_ready`=0 for 5 cycles, `DEPTH`=2:
  - Exactly 2 pushes, then `imem_req`=0.
  - Head stays at pc 0.
  - Releasing ready drains in order.
- 3-cycle-latency memory, redirect to `0x100` on the second wait cycle:
  - The stale word is discarded.
  - The next `imem_addr` is `0x100`.
  - The first valid output has `instr_pc`=`0x100`.
- `redirect` coinciding with `imem_ack` and a pop:
  - FIFO empties.
  - The acked word never appears.
  - `imem_addr`=`redirect_pc` next cycle.
- PC wrap: redirect to `0xFFFF_FFFC`:
  - `pc_plus4`=0.
  - The next fetch address is `0x0000_0000`.
- Redirect to `0x102`:
  - With `IFETCH_ALIGN_CHECK_EN`: `fetch_misalign`=1 sticky, no further `imem_req` until `rst`.
  - Without it: fetch resumes at `0x100`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_DROP,
        FS_FAULT
    } fetch_state_t;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t WORD_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small DEPTH-entry FIFO of {pc, instr} fetch results.
// Latency: push visible at head the next cycle; head is read combinationally.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
//
// Ports: clk/rst (sync, active-high), push + push_entry, pop, flush (wins over
// push and pop), count (0..DEPTH), head (entry at the read pointer).
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one-at-a-time imem reads, buffers words for decode.
// Latency: imem_ack to instr_valid 1 cycle; 1 instr/cycle sustained with zero-wait memory.
// Backpressure: stops requesting when the FIFO would fill; head held stable while !instr_ready.
//
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata
// memory side; redirect/redirect_pc from branch resolution; instr_valid/
// instr_ready/instr/instr_pc/pc_plus4 to decode; fetch_misalign sticky fault.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault on misaligned redirects.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_misalign
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    word_t         r_pc;          // next address to fetch
    word_t         w_pc_nxt;
    word_t         r_addr;        // address of the request on the bus
    logic          r_req;
    logic          w_redir;
    logic          w_push;
    logic          w_pop;
    logic          w_fault;
    word_t         w_target;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_bad_pc;

    assign w_target = redirect_pc;
    assign w_bad_pc = w_redir && (redirect_pc[1:0] != 2'b00);
    // Once set, every later landing point (drop completion) heads to the fault state.
    assign w_fault  = r_misalign || w_bad_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_bad_pc) begin
            r_misalign <= 1'b1;
        end
    end

    assign fetch_misalign = r_misalign;
`else
    assign w_target       = redirect_pc & ~word_t'(3);
    assign w_fault        = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // Redirects are meaningless once halted.
    assign w_redir = redirect && (r_state != FS_FAULT);
    // A redirect discards any word acked in the same cycle and blocks the pop.
    assign w_push  = (r_state == FS_REQ) && imem_ack && !w_redir;
    assign w_pop   = instr_valid && instr_ready && !w_redir;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    assign w_push_entry = '{pc: r_addr, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (w_redir),
        .count      (w_count),
        .head       (w_head)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            FS_IDLE: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = w_fault ? FS_FAULT : FS_REQ;
                end else if (w_count_nxt < DEPTH_C) begin
                    w_state_nxt = FS_REQ;
                end
            end
            FS_REQ: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    if (!imem_ack) begin
                        w_state_nxt = FS_DROP;
                    end else begin
                        w_state_nxt = w_fault ? FS_FAULT : FS_REQ;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt    = r_pc + WORD_BYTES;
                    w_state_nxt = (w_count_nxt < DEPTH_C) ? FS_REQ : FS_IDLE;
                end
            end
            FS_DROP: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_state_nxt = w_fault ? FS_FAULT : FS_REQ;
                end
            end
            FS_FAULT: begin
                w_state_nxt = FS_FAULT;
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= (w_state_nxt == FS_REQ) || (w_state_nxt == FS_DROP);
            // The bus address only moves when a fresh request (or idle) follows;
            // a dropped request keeps its old address until acked.
            if ((w_state_nxt == FS_REQ) || (w_state_nxt == FS_IDLE)) begin
                r_addr <= w_pc_nxt;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = (w_count != '0) && (r_state != FS_FAULT);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign pc_plus4    = w_head.pc + WORD_BYTES;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle tables for streaming, stall, redirect,
// wrap and misaligned redirect, plus a hand sequence against 3-wait memory.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        fetch_misalign;

    int n_checks = 0;
    int n_err    = 0;
    int mem_lat  = 0;
    int wait_cnt;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    // Memory model: acks after mem_lat cycles of an asserted request.
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t t1 [14];
    vec_t t2 [8];

    function automatic vec_t mkv(input logic rdy, input logic redir, input logic [31:0] rpc,
                                 input logic e_req, input logic chk_addr, input logic [31:0] e_addr,
                                 input logic e_vld, input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.chk_addr = chk_addr; v.e_addr = e_addr;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset imem_req",       32'(imem_req),       32'd0);
        chk("reset imem_addr",      imem_addr,           32'h0);
        chk("reset instr_valid",    32'(instr_valid),    32'd0);
        chk("reset instr",          instr,               32'h0);
        chk("reset instr_pc",       instr_pc,            32'h0);
        chk("reset pc_plus4",       pc_plus4,            32'h4);
        chk("reset fetch_misalign", 32'(fetch_misalign), 32'd0);
        rst = 1'b0;
    endtask

    task automatic check_row(input string tag, input int i, input vec_t v);
        chk($sformatf("%s[%0d] imem_req", tag, i), 32'(imem_req), 32'(v.e_req));
        if (v.chk_addr)
            chk($sformatf("%s[%0d] imem_addr", tag, i), imem_addr, v.e_addr);
        chk($sformatf("%s[%0d] instr_valid", tag, i), 32'(instr_valid), 32'(v.e_vld));
        if (v.e_vld) begin
            chk($sformatf("%s[%0d] instr_pc", tag, i), instr_pc, v.e_pc);
            chk($sformatf("%s[%0d] instr", tag, i), instr, mem_word(v.e_pc));
            chk($sformatf("%s[%0d] pc_plus4", tag, i), pc_plus4, v.e_pc + 32'd4);
        end
        chk($sformatf("%s[%0d] fetch_misalign", tag, i), 32'(fetch_misalign), 32'(v.e_mis));
    endtask

    task automatic apply_row(input vec_t v);
        instr_ready = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int    k_found;
        logic  got;

        // Row i is checked at the negedge after the i-th rising edge with rst low,
        // then its inputs are driven for the following edge.
        // Streaming, redirect with ack+pop, PC wrap, misaligned redirect.
        t1[0]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0000, 0, 32'h0,          0);
        t1[1]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0004, 1, 32'h0000_0000, 0);
        t1[2]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0008, 1, 32'h0000_0004, 0);
        t1[3]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_000C, 1, 32'h0000_0008, 0);
        t1[4]  = mkv(1, 1, 32'h0000_0200,  1, 1, 32'h0000_0010, 1, 32'h0000_000C, 0);
        t1[5]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0200, 0, 32'h0,          0);
        t1[6]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0204, 1, 32'h0000_0200, 0);
        t1[7]  = mkv(1, 1, 32'hFFFF_FFFC,  1, 1, 32'h0000_0208, 1, 32'h0000_0204, 0);
        t1[8]  = mkv(1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 0, 32'h0,          0);
        t1[9]  = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
        t1[10] = mkv(1, 1, 32'h0000_0102,  1, 1, 32'h0000_0004, 1, 32'h0000_0000, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        t1[11] = mkv(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,          1);
        t1[12] = mkv(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,          1);
        t1[13] = mkv(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,          1);
`else
        t1[11] = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0100, 0, 32'h0,          0);
        t1[12] = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0104, 1, 32'h0000_0100, 0);
        t1[13] = mkv(1, 0, 32'h0,          1, 1, 32'h0000_0108, 1, 32'h0000_0104, 0);
`endif
        // Decode stalled for 5 cycles: two pushes fill the FIFO, then drain in order.
        t2[0] = mkv(0, 0, 32'h0, 1, 1, 32'h0000_0000, 0, 32'h0,         0);
        t2[1] = mkv(0, 0, 32'h0, 1, 1, 32'h0000_0004, 1, 32'h0000_0000, 0);
        t2[2] = mkv(0, 0, 32'h0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        t2[3] = mkv(0, 0, 32'h0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        t2[4] = mkv(1, 0, 32'h0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        t2[5] = mkv(1, 0, 32'h0, 1, 1, 32'h0000_0008, 1, 32'h0000_0004, 0);
        t2[6] = mkv(1, 0, 32'h0, 1, 1, 32'h0000_000C, 1, 32'h0000_0008, 0);
        t2[7] = mkv(1, 0, 32'h0, 1, 1, 32'h0000_0010, 1, 32'h0000_000C, 0);

        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check_row("stream", i, t1[i]);
            apply_row(t1[i]);
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_row("stall", i, t2[i]);
            apply_row(t2[i]);
        end

        // 3-wait memory, redirect on the second wait cycle of the first request.
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("lat3 r0 imem_req",  32'(imem_req), 32'd1);
        chk("lat3 r0 imem_ack",  32'(imem_ack), 32'd0);
        @(negedge clk);
        chk("lat3 r1 imem_ack",  32'(imem_ack), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect    = 1'b0;
        chk("lat3 r2 imem_req",    32'(imem_req),    32'd1);
        chk("lat3 r2 held addr",   imem_addr,        32'h0);
        chk("lat3 r2 instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("lat3 r3 imem_ack",    32'(imem_ack),    32'd1);
        chk("lat3 r3 addr",        imem_addr,        32'h0);
        @(negedge clk);
        chk("lat3 r4 imem_req",    32'(imem_req),    32'd1);
        chk("lat3 r4 new addr",    imem_addr,        32'h0000_0100);
        chk("lat3 r4 instr_valid", 32'(instr_valid), 32'd0);
        got     = 1'b0;
        k_found = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                got     = 1'b1;
                k_found = k;
                chk("lat3 first instr_pc", instr_pc, 32'h0000_0100);
                chk("lat3 first instr",    instr,    mem_word(32'h0000_0100));
            end
        end
        chk("lat3 valid seen",        32'(got), 32'd1);
        chk("lat3 cycles to valid",   k_found,  32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
